// File: rtl/vx_writeback_arbiter_pkg.sv
// rtl/vx_writeback_arbiter_pkg.sv - shared constants, beat struct and index helpers for the writeback arbiter
package vx_writeback_arbiter_pkg;

  localparam int NUM_UNITS_DEF   = 5;
  localparam int NUM_THREADS_DEF = 4;
  localparam int NW_BITS_DEF     = 2;
  localparam int NR_BITS_DEF     = 6;

  // Commit source indices; lower index wins first after reset.
  localparam int EX_ALU = 0;
  localparam int EX_LSU = 1;
  localparam int EX_CSR = 2;
  localparam int EX_FPU = 3;
  localparam int EX_GPU = 4;

  // One writeback beat as held in the output register.
  typedef struct packed {
    logic [NW_BITS_DEF-1:0]       wid;
    logic [NUM_THREADS_DEF-1:0]   tmask;
    logic [31:0]                  PC;
    logic [NR_BITS_DEF-1:0]       rd;
    logic                         eop;
    logic [NUM_THREADS_DEF*32-1:0] data;
  } wb_beat_t;

  // Index width that stays legal for a single-source build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Position 'offset' slots after 'base' on a ring of n sources.
  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/vx_writeback_arbiter_if.sv
// rtl/vx_writeback_arbiter_if.sv - commit-side and GPR-side handshake bundle for the writeback arbiter
interface vx_writeback_arbiter_if
  import vx_writeback_arbiter_pkg::*;
#(
  parameter int NUM_UNITS   = NUM_UNITS_DEF,
  parameter int NUM_THREADS = NUM_THREADS_DEF,
  parameter int NW_BITS     = NW_BITS_DEF,
  parameter int NR_BITS     = NR_BITS_DEF
);

  logic [NUM_UNITS-1:0]                commit_valid;
  logic [NUM_UNITS-1:0]                commit_ready;
  logic [NUM_UNITS*NW_BITS-1:0]        commit_wid;
  logic [NUM_UNITS*NUM_THREADS-1:0]    commit_tmask;
  logic [NUM_UNITS*32-1:0]             commit_PC;
  logic [NUM_UNITS*NR_BITS-1:0]        commit_rd;
  logic [NUM_UNITS-1:0]                commit_wb;
  logic [NUM_UNITS-1:0]                commit_eop;
  logic [NUM_UNITS*NUM_THREADS*32-1:0] commit_data;

  logic                                wb_valid;
  logic                                wb_ready;
  logic [NW_BITS-1:0]                  wb_wid;
  logic [NUM_THREADS-1:0]              wb_tmask;
  logic [31:0]                         wb_PC;
  logic [NR_BITS-1:0]                  wb_rd;
  logic                                wb_eop;
  logic [NUM_THREADS*32-1:0]           wb_data;

  // Arbiter side: consumes commits, produces writebacks.
  modport slave (
    input  commit_valid, commit_wid, commit_tmask, commit_PC, commit_rd,
           commit_wb, commit_eop, commit_data, wb_ready,
    output commit_ready, wb_valid, wb_wid, wb_tmask, wb_PC, wb_rd, wb_eop, wb_data
  );

  // Environment side: execute units plus the GPR file.
  modport master (
    output commit_valid, commit_wid, commit_tmask, commit_PC, commit_rd,
           commit_wb, commit_eop, commit_data, wb_ready,
    input  commit_ready, wb_valid, wb_wid, wb_tmask, wb_PC, wb_rd, wb_eop, wb_data
  );

endinterface

// File: rtl/vx_writeback_arbiter_rr_arbiter.sv
// rtl/vx_writeback_arbiter_rr_arbiter.sv - round-robin picker with a last-grant pointer
module vx_rr_arbiter
  import vx_writeback_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = NUM_UNITS_DEF,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] requests,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] last_grant;

  // Search the ring starting one past the previous winner; first requester wins.
  always_comb begin
    int cand;
    cand        = 0;
    grant       = '0;
    grant_idx   = last_grant;
    grant_valid = 1'b0;
    if (enable) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = rr_index(int'(last_grant), k, NUM_REQ);
        if (!grant_valid && requests[cand]) begin
          grant_valid = 1'b1;
          grant[cand] = 1'b1;
          grant_idx   = IDX_W'(cand);
        end
      end
    end
  end

  // Pointer moves only when a grant is actually taken; starts at the top so index 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (grant_valid) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/vx_writeback_arbiter.sv
// rtl/vx_writeback_arbiter.sv - serialises unit commit streams into one registered GPR writeback stream (optional WB_ARB_PERF_EN)
module vx_writeback_arbiter
  import vx_writeback_arbiter_pkg::*;
#(
  parameter int NUM_UNITS   = NUM_UNITS_DEF,
  parameter int NUM_THREADS = NUM_THREADS_DEF,
  parameter int NW_BITS     = NW_BITS_DEF,
  parameter int NR_BITS     = NR_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  vx_writeback_arbiter_if.slave bus
`ifdef WB_ARB_PERF_EN
  ,
  output logic [63:0]           perf_instrs
`endif
);

  localparam int IDX_W = idx_width(NUM_UNITS);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  lock_state_e          lock_state;
  logic [IDX_W-1:0]     lock_unit;

  logic                 out_free;
  logic [NUM_UNITS-1:0] req;
  logic [NUM_UNITS-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 accept;

  wb_beat_t             sel_beat;
  logic                 sel_wb;
  wb_beat_t             beat_q;
  logic                 wb_valid_q;

  // The output slot can take a beat when empty or draining; nothing is accepted during reset.
  assign out_free = !reset && (!wb_valid_q || bus.wb_ready);

  // While a packet is open only its owner may compete, even if it is idle.
  always_comb begin
    req = bus.commit_valid;
    if (lock_state == ST_LOCKED) begin
      req            = '0;
      req[lock_unit] = bus.commit_valid[lock_unit];
    end
  end

  vx_rr_arbiter #(
    .NUM_REQ (NUM_UNITS)
  ) u_rr_arbiter (
    .clk         (clk),
    .reset       (reset),
    .requests    (req),
    .enable      (out_free),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (accept)
  );

  assign bus.commit_ready = grant;

  // One-hot mux of the winning unit's beat fields.
  always_comb begin
    sel_beat = '0;
    sel_wb   = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (grant[u]) begin
        sel_beat.wid   = bus.commit_wid[u*NW_BITS +: NW_BITS];
        sel_beat.tmask = bus.commit_tmask[u*NUM_THREADS +: NUM_THREADS];
        sel_beat.PC    = bus.commit_PC[u*32 +: 32];
        sel_beat.rd    = bus.commit_rd[u*NR_BITS +: NR_BITS];
        sel_beat.eop   = bus.commit_eop[u];
        sel_beat.data  = bus.commit_data[u*NUM_THREADS*32 +: NUM_THREADS*32];
        sel_wb         = bus.commit_wb[u];
      end
    end
  end

  // Output register: holds while stalled, loads a forwarded beat, empties on a non-writeback beat or idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      beat_q     <= '0;
    end else if (out_free) begin
      wb_valid_q <= accept && sel_wb;
      if (accept && sel_wb) begin
        beat_q <= sel_beat;
      end
    end
  end

  // Grant lock: opens on an accepted non-final beat, closes on the owner's final beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_state <= ST_UNLOCKED;
      lock_unit  <= '0;
    end else if (accept) begin
      if (sel_beat.eop) begin
        lock_state <= ST_UNLOCKED;
      end else begin
        lock_state <= ST_LOCKED;
        lock_unit  <= grant_idx;
      end
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_wid   = beat_q.wid;
  assign bus.wb_tmask = beat_q.tmask;
  assign bus.wb_PC    = beat_q.PC;
  assign bus.wb_rd    = beat_q.rd;
  assign bus.wb_eop   = beat_q.eop;
  assign bus.wb_data  = beat_q.data;

`ifdef WB_ARB_PERF_EN
  logic [63:0] perf_q;

  // Retired-instruction count: every accepted final beat, forwarded or not.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else if (accept && sel_beat.eop) begin
      perf_q <= perf_q + 64'd1;
    end
  end

  assign perf_instrs = perf_q;
`endif

endmodule

// File: tb/tb_vx_writeback_arbiter.sv
// tb/tb_vx_writeback_arbiter.sv - directed and randomised checks of the writeback arbiter against a reference model
module tb_vx_writeback_arbiter;
  import vx_writeback_arbiter_pkg::*;

  localparam int N  = 5;
  localparam int T  = 4;
  localparam int NW = 2;
  localparam int NR = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_writeback_arbiter_if bus ();

`ifdef WB_ARB_PERF_EN
  logic [63:0] perf_instrs;
`endif

  vx_writeback_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus)
`ifdef WB_ARB_PERF_EN
    ,
    .perf_instrs (perf_instrs)
`endif
  );

  // Stimulus per unit
  logic [N-1:0]    s_valid, s_wb, s_eop;
  logic [NW-1:0]   s_wid   [N];
  logic [T-1:0]    s_tmask [N];
  logic [31:0]     s_pc    [N];
  logic [NR-1:0]   s_rd    [N];
  logic [T*32-1:0] s_data  [N];
  logic            s_wb_ready;

  // Reference model
  logic            m_valid;
  logic [191:0]    m_beat;
  int              m_last;
  int              m_lock;
  logic [63:0]     m_perf;
  int              grant_log[$];
  logic [N-1:0]    last_ready;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int u = 0; u < N; u++) begin
      bus.commit_valid[u]             = s_valid[u];
      bus.commit_wb[u]                = s_wb[u];
      bus.commit_eop[u]               = s_eop[u];
      bus.commit_wid[u*NW +: NW]      = s_wid[u];
      bus.commit_tmask[u*T +: T]      = s_tmask[u];
      bus.commit_PC[u*32 +: 32]       = s_pc[u];
      bus.commit_rd[u*NR +: NR]       = s_rd[u];
      bus.commit_data[u*T*32 +: T*32] = s_data[u];
    end
    bus.wb_ready = s_wb_ready;
  endtask

  task automatic set_unit(input int u, input logic wb, input logic eop,
                          input logic [NR-1:0] rd, input logic [T*32-1:0] data);
    s_wb[u]    = wb;
    s_eop[u]   = eop;
    s_rd[u]    = rd;
    s_data[u]  = data;
    s_wid[u]   = NW'($urandom);
    s_tmask[u] = T'($urandom);
    s_pc[u]    = $urandom;
  endtask

  function automatic logic [T*32-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [191:0] beat_of(input int u);
    return 192'({s_wid[u], s_tmask[u], s_pc[u], s_rd[u], s_eop[u], s_data[u]});
  endfunction

  function automatic logic [191:0] wb_obs();
    return 192'({bus.wb_wid, bus.wb_tmask, bus.wb_PC, bus.wb_rd, bus.wb_eop, bus.wb_data});
  endfunction

  // Winner under the rules: owner only while locked, else first valid after the last winner.
  function automatic int pick();
    int u;
    for (int k = 1; k <= N; k++) begin
      u = (m_last + k) % N;
      if ((m_lock < 0 || m_lock == u) && s_valid[u]) return u;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    chk("wb_valid", 192'(bus.wb_valid), 192'(m_valid));
    if (m_valid) chk("wb_beat", wb_obs(), m_beat);
`ifdef WB_ARB_PERF_EN
    chk("perf_instrs", 192'(perf_instrs), 192'(m_perf));
`endif
  endtask

  // One clock: check ready mid-cycle, advance the model at the edge, check registered outputs after.
  task automatic step();
    int g;
    logic [N-1:0] exp_ready;
    apply();
    @(negedge clk);
    g = (m_valid && !s_wb_ready) ? -1 : pick();
    exp_ready = (g >= 0) ? (N'(1) << g) : '0;
    last_ready = bus.commit_ready;
    chk("commit_ready", 192'(bus.commit_ready), 192'(exp_ready));
    @(posedge clk);
    if (!(m_valid && !s_wb_ready)) begin
      if (g >= 0) begin
        m_last = g;
        grant_log.push_back(g);
        if (s_eop[g]) begin
          m_lock = -1;
          m_perf = m_perf + 64'd1;
        end else begin
          m_lock = g;
        end
        m_valid = s_wb[g];
        if (s_wb[g]) m_beat = beat_of(g);
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check_outputs();
  endtask

  // Reset with noisy inputs; nothing may be accepted while reset is high.
  task automatic do_reset();
    logic [N-1:0] keep_valid;
    keep_valid = s_valid;
    reset = 1'b1;
    s_valid = '1;
    s_wb_ready = 1'b1;
    apply();
    repeat (2) begin
      @(negedge clk);
      chk("reset_ready", 192'(bus.commit_ready), 192'(0));
      @(posedge clk);
    end
    #1;
    reset = 1'b0;
    m_valid = 1'b0;
    m_beat = '0;
    m_last = N - 1;
    m_lock = -1;
    m_perf = '0;
    chk("reset_wb_valid", 192'(bus.wb_valid), 192'(0));
    chk("reset_wb_fields", wb_obs(), 192'(0));
`ifdef WB_ARB_PERF_EN
    chk("reset_perf", 192'(perf_instrs), 192'(0));
`endif
    s_valid = keep_valid;
    apply();
  endtask

  initial begin
    int cnt[N];
    int order[3];
    logic [NR-1:0] rd_a, rd_b;

    reset = 1'b1;
    s_valid = '0; s_wb = '0; s_eop = '0; s_wb_ready = 1'b1;
    for (int u = 0; u < N; u++) set_unit(u, 1'b1, 1'b1, '0, '0);

    // Single beat from the ALU
    s_valid = '0;
    do_reset();
    set_unit(EX_ALU, 1'b1, 1'b1, NR'(5), {4{32'h0000_00A5}});
    s_valid = 5'b00001;
    step();
    chk("t1_ready", 192'(last_ready), 192'(5'b00001));
    chk("t1_rd", 192'(bus.wb_rd), 192'(5));
    chk("t1_data", 192'(bus.wb_data), 192'({4{32'h0000_00A5}}));
    s_valid = '0;
    step();

    // Fairness among units 0, 2, 4
    s_valid = '0;
    do_reset();
    for (int u = 0; u < N; u++) set_unit(u, 1'b1, 1'b1, NR'($urandom), rand_data());
    s_valid = 5'b10101;
    grant_log.delete();
    repeat (9) step();
    order[0] = EX_ALU; order[1] = EX_CSR; order[2] = EX_GPU;
    chk("t2_beats", 192'(grant_log.size()), 192'(9));
    for (int u = 0; u < N; u++) cnt[u] = 0;
    for (int i = 0; i < grant_log.size(); i++) begin
      cnt[grant_log[i]]++;
      chk("t2_order", 192'(grant_log[i]), 192'(order[i % 3]));
    end
    chk("t2_alu_share", 192'(cnt[EX_ALU]), 192'(3));
    chk("t2_csr_share", 192'(cnt[EX_CSR]), 192'(3));
    chk("t2_gpu_share", 192'(cnt[EX_GPU]), 192'(3));
    s_valid = '0;
    step();

    // Lock: LSU three-beat packet while the ALU waits
    s_valid = '0;
    do_reset();
    set_unit(EX_LSU, 1'b1, 1'b0, NR'(1), rand_data());
    s_valid = 5'b00010;
    step();
    chk("t3_lsu_first", 192'(last_ready), 192'(5'b00010));
    set_unit(EX_ALU, 1'b1, 1'b1, NR'(2), rand_data());
    s_valid = 5'b00011;
    set_unit(EX_LSU, 1'b1, 1'b0, NR'(3), rand_data());
    step();
    chk("t3_alu_blocked_b2", 192'(last_ready), 192'(5'b00010));
    set_unit(EX_LSU, 1'b1, 1'b1, NR'(4), rand_data());
    step();
    chk("t3_alu_blocked_b3", 192'(last_ready), 192'(5'b00010));
    s_valid = 5'b00001;
    step();
    chk("t3_alu_after_eop", 192'(last_ready), 192'(5'b00001));
    s_valid = '0;
    step();

    // Backpressure with the CSR
    s_valid = '0;
    do_reset();
    rd_a = NR'(11);
    rd_b = NR'(22);
    set_unit(EX_CSR, 1'b1, 1'b1, rd_a, rand_data());
    s_valid = 5'b00100;
    s_wb_ready = 1'b1;
    step();
    set_unit(EX_CSR, 1'b1, 1'b1, rd_b, rand_data());
    s_wb_ready = 1'b0;
    repeat (4) begin
      step();
      chk("t4_stall_ready", 192'(last_ready), 192'(0));
      chk("t4_stall_rd", 192'(bus.wb_rd), 192'(rd_a));
    end
    s_wb_ready = 1'b1;
    step();
    chk("t4_drain_ready", 192'(last_ready), 192'(5'b00100));
    chk("t4_new_rd", 192'(bus.wb_rd), 192'(rd_b));
    s_valid = '0;
    step();

    // GPU beat without writeback
    s_valid = '0;
    do_reset();
    set_unit(EX_GPU, 1'b0, 1'b1, NR'(7), rand_data());
    s_valid = 5'b10000;
    step();
    chk("t5_ready", 192'(last_ready), 192'(5'b10000));
    chk("t5_wb_valid", 192'(bus.wb_valid), 192'(0));
`ifdef WB_ARB_PERF_EN
    chk("t5_perf", 192'(perf_instrs), 192'(1));
`endif
    s_valid = '0;
    step();

    // Reset in the middle of an LSU packet
    set_unit(EX_LSU, 1'b1, 1'b0, NR'(9), rand_data());
    s_valid = 5'b00010;
    step();
    set_unit(EX_ALU, 1'b1, 1'b1, NR'(8), rand_data());
    s_valid = 5'b00011;
    do_reset();
    step();
    chk("t6_alu_first", 192'(last_ready), 192'(5'b00001));
    s_valid = '0;
    step();

    // Randomised traffic with random backpressure
    s_valid = '0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int u = 0; u < N; u++) begin
        set_unit(u, ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1), NR'($urandom), rand_data());
        s_valid[u] = ($urandom_range(0, 9) < 6);
      end
      s_wb_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    s_valid = '0;
    s_wb_ready = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vx_writeback_arbiter.md
Name: vx_writeback_arbiter

Overview:
- Return path of the execute stage: collects per-unit commit streams (ALU, LSU, CSR, FPU, GPU) and serialises them into one GPR writeback stream.
- Round-robin arbitration, with grant lock across multi-beat packets (eop).
- Registered output, so valid/ready handshakes at the unit side and the GPR side are decoupled.

Parameters:
- NUM_UNITS, 5, number of commit sources; index order ALU=0, LSU=1, CSR=2, FPU=3, GPU=4.
- NUM_THREADS, 4, lanes per warp.
- NW_BITS, 2, warp-id width.
- NR_BITS, 6, register-index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- commit_valid  in  NUM_UNITS  per-unit commit valid
- commit_ready  out  NUM_UNITS  per-unit accept
- commit_wid  in  NUM_UNITS*NW_BITS  warp id
- commit_tmask  in  NUM_UNITS*NUM_THREADS  thread mask
- commit_PC  in  NUM_UNITS*32  instruction PC
- commit_rd  in  NUM_UNITS*NR_BITS  destination register
- commit_wb  in  NUM_UNITS  1 = write GPR
- commit_eop  in  NUM_UNITS  last beat of instruction
- commit_data  in  NUM_UNITS*NUM_THREADS*32  result data
- wb_valid  out  1  writeback valid
- wb_ready  in  1  GPR accepts
- wb_wid, wb_tmask, wb_PC, wb_rd, wb_eop  out  NW_BITS, NUM_THREADS, 32, NR_BITS, 1  registered writeback fields
- wb_data  out  NUM_THREADS*32  registered result data

Behaviour:
- Output register stalls when wb_valid=1 and wb_ready=0. Otherwise it is free: empty, or draining this cycle.
- Grant is combinational and applies only while the output register is free.
  - Unlocked: round-robin among asserted commit_valid, searching from (last_grant+1) mod NUM_UNITS.
  - Locked: only the locked unit is eligible.
- commit_ready is one-hot, asserted only for the granted unit and only when the output register is free. Transfer = valid & ready.
- Accepted beat with wb=1: loads the output register next edge; wb_valid=1. Latency 1 cycle, throughput 1 beat/cycle.
- Accepted beat with wb=0: consumed but not forwarded; wb_valid goes 0 next cycle unless another beat loads. The beat still uses the arbitration slot and updates last_grant.
- Lock FSM:
  - UNLOCKED to LOCKED(u) on accepting a beat from unit u with eop=0.
  - LOCKED(u) to UNLOCKED on accepting a beat from u with eop=1.
  - While locked, other units see commit_ready=0, even if u is idle.
- last_grant updates on every accepted beat. Held during stalls and idle cycles.
- Data fields in the output register are held while stalled. They are don't-care while wb_valid=0.
- Reset:
  - wb_valid=0, commit_ready=0, last_grant=NUM_UNITS-1 (so unit 0 wins first), FSM=UNLOCKED. All other wb_* fields are 0.
  - Reset mid-packet drops the lock and any held beat.
- Simultaneous drain (wb_ready=1) and load in the same cycle: the register takes the new beat with no bubble.
- NUM_UNITS=1: arbiter degenerates to pass-through plus register. Must elaborate.

Optional Feature:
- Macro WB_ARB_PERF_EN.
- Defined: adds output perf_instrs[63:0], reset 0. Increments by 1 on each accepted beat with eop=1, whether wb=1 or wb=0. Wraps at 2^64.
- Undefined: port and counter are absent, with no other behavioural difference.

Decomposition:
- Shared package holds the unit-index constants (EX_ALU..EX_GPU), the wb beat struct (wid, tmask, PC, rd, eop, data) and the NUM_UNITS default.
- One natural sub-module: vx_rr_arbiter (request vector, enable, one-hot grant, grant index, last_grant register). Locking stays in the top module.

Test Plan:
- Single beat: after reset, ALU valid, wb=1, rd=5, data=0xA5 in all lanes -> ready same cycle. Next cycle wb_valid=1, wb_rd=5, wb_data lanes=0xA5.
- Fairness: units 0, 2, 4 held valid continuously, wb_ready=1 -> grant order 0, 2, 4, 0, 2, 4. Each unit gets exactly 3 of 9 beats.
- Lock: LSU sends 3 beats (eop=0,0,1) while ALU is valid throughout -> ALU ready stays 0 until after the LSU eop=1 beat is accepted. ALU is granted the next cycle.
- Backpressure: wb_ready=0 for 4 cycles with CSR valid -> all commit_ready=0 and wb fields stable. wb_ready=1 -> held beat drains and the CSR beat loads that same cycle.
- No-writeback: GPU beat with wb=0 -> accepted and wb_valid stays 0. With WB_ARB_PERF_EN, perf_instrs goes 0 -> 1.
- Reset mid-lock: reset asserted after LSU eop=0 beat -> wb_valid=0. After release, ALU (unit 0) is granted first.
